// File: rtl/ps2_device_emu.sv
// Device-side PS/2 endpoint emulating a keyboard or mouse. It generates PS2CLK, sends
// 11-bit frames to the host and receives host-to-device commands with a line-level ACK.
module ps2_device_emu #(
    parameter int unsigned HALF_CYC = 2000,
    parameter int unsigned IDLE_CYC = 2500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_perr,
    output logic       rx_ferr,
    output logic       tx_abort,
    output logic       busy,
    input  logic       ps2clk_i,
    input  logic       ps2data_i,
    output logic       ps2clk_oe,
    output logic       ps2data_oe
);
    localparam int unsigned TW = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam int unsigned IW = $clog2(IDLE_CYC + 1);

    typedef enum logic [2:0] {
        StIdle,
        StTxHigh,
        StTxLow,
        StRxWait,
        StRxLow,
        StRxHigh,
        StAckLow,
        StAckHigh
    } state_e;

    state_e        state_q, state_d;
    logic          clk_meta_q, sclk, dat_meta_q, sdat;
    logic [IW-1:0] idle_cnt_q;
    logic          bus_idle;
    logic [TW-1:0] timer_q;
    logic          tick;
    logic          pending_q, pending_d;
    logic [7:0]    hold_q;
    logic          accept;
    logic [10:0]   shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    rx_sr_q, rx_sr_d;
    logic [7:0]    rx_data_d;
    logic          rx_valid_d, rx_perr_d, rx_ferr_d, tx_abort_d;
    logic          clk_oe_d, data_oe_d;
    logic [1:0]    oe_hist_q;
    logic          rts;

    assign bus_idle = (idle_cnt_q == IW'(IDLE_CYC));
    assign tick     = (timer_q == TW'(HALF_CYC - 1));
    assign accept   = tx_valid & ~pending_q;
    assign tx_ready = ~pending_q;
    assign busy     = (state_q != StIdle);
    // Our own ACK drive is still in the synchronizer for two cycles after release;
    // ignore sdat=0 until it has flushed so we do not answer ourselves.
    assign rts      = sclk & ~sdat & ~(|oe_hist_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            sclk       <= 1'b1;
            dat_meta_q <= 1'b1;
            sdat       <= 1'b1;
            idle_cnt_q <= '0;
            timer_q    <= '0;
        end else begin
            clk_meta_q <= ps2clk_i;
            sclk       <= clk_meta_q;
            dat_meta_q <= ps2data_i;
            sdat       <= dat_meta_q;
            if (sclk && sdat) begin
                if (!bus_idle) idle_cnt_q <= idle_cnt_q + IW'(1);
            end else begin
                idle_cnt_q <= '0;
            end
            if ((state_d != state_q) || tick) timer_q <= '0;
            else                              timer_q <= timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pending_q  <= 1'b0;
            hold_q     <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            rx_sr_q    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_perr    <= 1'b0;
            rx_ferr    <= 1'b0;
            tx_abort   <= 1'b0;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            oe_hist_q  <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            if (accept) hold_q <= tx_data;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sr_q    <= rx_sr_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
            rx_perr    <= rx_perr_d;
            rx_ferr    <= rx_ferr_d;
            tx_abort   <= tx_abort_d;
            ps2clk_oe  <= clk_oe_d;
            ps2data_oe <= data_oe_d;
            oe_hist_q  <= {oe_hist_q[0], ps2data_oe};
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q | accept;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data;
        rx_perr_d  = rx_perr;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        tx_abort_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (rts) begin
                    state_d = StRxWait;
                end else if (pending_q && bus_idle) begin
                    state_d   = StTxHigh;
                    shift_d   = {1'b1, ~^hold_q, hold_q, 1'b0};
                    bit_cnt_d = '0;
                end
            end
            StTxHigh: begin
                if (tick) begin
                    if (!sclk) begin
                        tx_abort_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        state_d = StTxLow;
                    end
                end
            end
            StTxLow: begin
                if (tick) begin
                    if (bit_cnt_q == 4'd10) begin
                        state_d   = StIdle;
                        pending_d = 1'b0;
                    end else begin
                        shift_d   = {1'b0, shift_q[10:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        state_d   = StTxHigh;
                    end
                end
            end
            StRxWait: begin
                if (tick) begin
                    state_d   = StRxLow;
                    bit_cnt_d = '0;
                end
            end
            StRxLow: begin
                if (tick) state_d = StRxHigh;
            end
            StRxHigh: begin
                if (tick) begin
                    if (!sclk) begin
                        state_d = StIdle;
                    end else if (bit_cnt_q == 4'd9) begin
                        if (sdat) begin
                            state_d = StAckLow;
                        end else begin
                            rx_ferr_d = 1'b1;
                            state_d   = StIdle;
                        end
                    end else begin
                        rx_sr_d   = {sdat, rx_sr_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        state_d   = StRxLow;
                    end
                end
            end
            StAckLow: begin
                if (tick) state_d = StAckHigh;
            end
            StAckHigh: begin
                if (tick) begin
                    state_d    = StIdle;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sr_q[7:0];
                    rx_perr_d  = ~^rx_sr_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pin drives are registered from the next state so they switch with state_q.
        clk_oe_d = (state_d == StTxLow) || (state_d == StRxLow) || (state_d == StAckLow);
        if ((state_d == StTxHigh) || (state_d == StTxLow)) begin
            data_oe_d = ~shift_d[0];
        end else begin
            data_oe_d = (state_d == StAckLow) || (state_d == StAckHigh);
        end
    end

endmodule

// File: tb/tb_ps2_device_emu.sv
// Self-checking bench for ps2_device_emu: a host model on the open-drain pins plus
// scoreboards for bytes sent to the host and bytes received from it.
module tb_ps2_device_emu;
    localparam int unsigned HALF = 4;
    localparam int unsigned IDLE = 10;
    localparam int          TO   = 400;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_perr, rx_ferr, tx_abort, busy;
    logic       ps2clk_oe, ps2data_oe;
    logic       host_clk_low, host_dat_low;
    logic       ps2clk_pin, ps2data_pin;

    assign ps2clk_pin  = ~(ps2clk_oe | host_clk_low);
    assign ps2data_pin = ~(ps2data_oe | host_dat_low);

    always #5 clk = ~clk;

    ps2_device_emu #(.HALF_CYC(HALF), .IDLE_CYC(IDLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_perr    (rx_perr),
        .rx_ferr    (rx_ferr),
        .tx_abort   (tx_abort),
        .busy       (busy),
        .ps2clk_i   (ps2clk_pin),
        .ps2data_i  (ps2data_pin),
        .ps2clk_oe  (ps2clk_oe),
        .ps2data_oe (ps2data_oe)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_rx_valid = 0;
    int          n_ferr  = 0;
    int          n_abort = 0;
    logic [8:0]  rx_exp_q[$];
    logic [10:0] tx_exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Receive-side monitor: every rx_valid pops one expected {perr, data}.
    initial begin : mon
        logic [31:0] rx_e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rx_valid) begin
                    n_rx_valid++;
                    if (rx_exp_q.size() != 0) rx_e = 32'(rx_exp_q.pop_front());
                    else                      rx_e = 32'hFFFF_FFFF;
                    check("rx_frame", 32'({rx_perr, rx_data}), rx_e);
                end
                if (rx_ferr)  n_ferr++;
                if (tx_abort) n_abort++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_clk_level(input logic lvl, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ps2clk_pin == lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_fall(input int limit, output bit ok);
        wait_clk_level(1'b1, limit, ok);
        if (ok) wait_clk_level(1'b0, limit, ok);
    endtask

    // Passive host: sample PS2DATA at each falling PS2CLK edge.
    task automatic host_capture(input int nbits, output logic [10:0] bits, output bit ok);
        bits = '0;
        ok   = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            wait_fall(TO, ok);
            if (!ok) return;
            bits[i] = ps2data_pin;
        end
    endtask

    task automatic send_tx(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("tx_ready_wait", 32'(ok), 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic host_rts();
        host_clk_low = 1'b1;
        repeat (10) @(negedge clk);
        host_dat_low = 1'b1;
        repeat (10) @(negedge clk);
        host_clk_low = 1'b0;
    endtask

    // Host shifts d0..d7, parity, stop on device clock falls, then looks for the ACK pulse.
    task automatic host_shift(input logic [7:0] b, input logic par, input logic stop,
                              output int pulses, output logic ack, output bit ok);
        logic [9:0] bits;
        bit         k;
        bits   = {stop, par, b};
        pulses = 0;
        ack    = 1'b0;
        ok     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_fall(TO, k);
            if (!k) begin
                ok = 1'b0;
                return;
            end
            pulses++;
            host_dat_low = ~bits[i];
        end
        // Let go of the line between the stop sample and the device's return to idle.
        wait_clk_level(1'b1, TO, k);
        ok = ok & k;
        repeat (HALF - 2) @(negedge clk);
        host_dat_low = 1'b0;
        if (stop) begin
            wait_fall(TO, k);
            ok = ok & k;
            if (k) begin
                pulses++;
                ack = ps2data_oe;
                wait_clk_level(1'b1, TO, k);
                ok = ok & k;
            end
        end
    endtask

    initial begin
        logic [10:0] cap;
        logic [10:0] exp_f;
        bit          ok;
        int          pulses;
        logic        ack;
        int          base;

        reset        = 1'b1;
        tx_data      = '0;
        tx_valid     = 1'b0;
        host_clk_low = 1'b0;
        host_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", 32'(tx_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_oe", 32'({ps2clk_oe, ps2data_oe}), 0);
        check("rst_rx", 32'({rx_data, rx_valid, rx_perr, rx_ferr, tx_abort}), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Transmit 0x1C: host sees 0,0,0,1,1,1,0,0,0,0,1.
        tx_exp_q.push_back(11'b100_0011_1000);
        send_tx(8'h1C);
        host_capture(11, cap, ok);
        check("tx1c_timeout", 32'(ok), 1);
        check("tx1c_ready_last_low", 32'({tx_ready, busy}), 32'b01);
        exp_f = (tx_exp_q.size() != 0) ? tx_exp_q.pop_front() : 11'h7FF;
        check("tx1c_frame", 32'(cap), 32'(exp_f));
        wait_clk_level(1'b1, TO, ok);
        check("tx1c_ready_after", 32'(tx_ready), 1);
        repeat (30) @(negedge clk);

        // Receive 0xED with good parity.
        base = n_rx_valid;
        rx_exp_q.push_back({1'b0, 8'hED});
        host_rts();
        host_shift(8'hED, 1'b1, 1'b1, pulses, ack, ok);
        check("rx_ed_timeout", 32'(ok), 1);
        check("rx_ed_pulses", 32'(pulses), 11);
        check("rx_ed_ack", 32'(ack), 1);
        repeat (20) @(negedge clk);
        check("rx_ed_valid_cnt", 32'(n_rx_valid), 32'(base + 1));
        repeat (20) @(negedge clk);

        // Receive 0xED with bad parity: still ACKed, rx_perr=1.
        base = n_rx_valid;
        rx_exp_q.push_back({1'b1, 8'hED});
        host_rts();
        host_shift(8'hED, 1'b0, 1'b1, pulses, ack, ok);
        check("rx_perr_pulses", 32'(pulses), 11);
        check("rx_perr_ack", 32'(ack), 1);
        repeat (20) @(negedge clk);
        check("rx_perr_valid_cnt", 32'(n_rx_valid), 32'(base + 1));
        repeat (20) @(negedge clk);

        // Stop bit 0: frame error, no ACK pulse, no rx_valid.
        base = n_ferr;
        host_rts();
        host_shift(8'hED, 1'b1, 1'b0, pulses, ack, ok);
        check("ferr_pulses", 32'(pulses), 10);
        repeat (10) @(negedge clk);
        check("ferr_pulse_cnt", 32'(n_ferr), 32'(base + 1));
        wait_fall(100, ok);
        check("ferr_no_ack", 32'(ok), 0);
        check("ferr_no_valid", 32'(n_rx_valid), 2);
        repeat (20) @(negedge clk);

        // Host inhibits during the high phase of bit 4 of 0xAA; full frame is resent.
        base = n_abort;
        tx_exp_q.push_back(frame_of(8'hAA));
        send_tx(8'hAA);
        host_capture(4, cap, ok);
        check("abort_partial", 32'(cap[3:0]), 32'(frame_of(8'hAA) & 11'hF));
        wait_clk_level(1'b1, TO, ok);
        host_clk_low = 1'b1;
        repeat (HALF + 4) @(negedge clk);
        check("abort_pulse_cnt", 32'(n_abort), 32'(base + 1));
        check("abort_released", 32'({ps2clk_oe, ps2data_oe, busy}), 0);
        check("abort_tx_ready", 32'(tx_ready), 0);
        repeat (20) @(negedge clk);
        host_clk_low = 1'b0;
        host_capture(11, cap, ok);
        check("abort_retry_timeout", 32'(ok), 1);
        exp_f = (tx_exp_q.size() != 0) ? tx_exp_q.pop_front() : 11'h7FF;
        check("abort_retry_frame", 32'(cap), 32'(exp_f));
        wait_clk_level(1'b1, TO, ok);
        check("abort_retry_ready", 32'(tx_ready), 1);
        repeat (30) @(negedge clk);

        // Request-to-send and a pending 0x55 reach the idle FSM in the same cycle.
        base = n_rx_valid;
        rx_exp_q.push_back({1'b0, 8'hA5});
        tx_exp_q.push_back(frame_of(8'h55));
        host_dat_low = 1'b1;
        tx_data      = 8'h55;
        @(negedge clk);
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        host_shift(8'hA5, ~^8'hA5, 1'b1, pulses, ack, ok);
        check("sim_rx_pulses", 32'(pulses), 11);
        check("sim_rx_ack", 32'(ack), 1);
        check("sim_pending", 32'(tx_ready), 0);
        host_capture(11, cap, ok);
        check("sim_rx_first", 32'(n_rx_valid), 32'(base + 1));
        exp_f = (tx_exp_q.size() != 0) ? tx_exp_q.pop_front() : 11'h7FF;
        check("sim_tx_frame", 32'(cap), 32'(exp_f));
        repeat (30) @(negedge clk);

        // Reset in the middle of a receive, after five bits.
        base = n_rx_valid;
        host_rts();
        for (int i = 0; i < 5; i++) begin
            wait_fall(TO, ok);
            host_dat_low = ~i[0];
        end
        @(negedge clk);
        reset        = 1'b1;
        host_dat_low = 1'b0;
        host_clk_low = 1'b0;
        @(negedge clk);
        check("rst_mid_oe", 32'({ps2clk_oe, ps2data_oe}), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_rx", 32'({rx_data, rx_valid}), 0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("rst_mid_no_valid", 32'(n_rx_valid), 32'(base));
        check("rst_mid_idle", 32'({busy, ps2clk_oe}), 0);

        check("rx_sb_drained", 32'(rx_exp_q.size()), 0);
        check("tx_sb_drained", 32'(tx_exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_device_emu.md
# ps2_device_emu

Device-side PS/2 endpoint that emulates a keyboard or mouse, so the PS/2 host interface can be exercised on-board and in simulation. It generates the PS/2 clock itself. It sends bytes to the host as 11-bit frames and receives host-to-device commands, returning the line-level ACK. It sits between a byte-stream source/sink (test sequencer or soft CPU) and the open-drain PS2CLK/PS2DATA pins. The top level wires the pins as `pin = oe ? 0 : z`.

## Interface
- HALF_CYC, 2000: clk cycles per PS/2 clock half-period. 50 MHz / 2000 / 2 = 12.5 kHz.
- IDLE_CYC, 2500: clk cycles the bus must be idle (clk=1, data=1) before a transmit starts (50 us).
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- tx_data  in  8  byte to send to host
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding register empty; accepts on tx_valid & tx_ready
- rx_data  out  8  last byte received from host
- rx_valid  out  1  one-cycle pulse, rx_data/rx_perr updated
- rx_perr  out  1  parity error on the last received byte (valid with rx_valid)
- rx_ferr  out  1  one-cycle pulse: stop bit sampled 0, frame dropped
- tx_abort  out  1  one-cycle pulse: host inhibited mid-frame, byte retained for retry
- busy  out  1  FSM not in IDLE
- ps2clk_i  in  1  PS2CLK pin level (asynchronous)
- ps2data_i  in  1  PS2DATA pin level (asynchronous)
- ps2clk_oe  out  1  1 = drive PS2CLK low
- ps2data_oe  out  1  1 = drive PS2DATA low

## Operation
- **Input sync:** ps2clk_i and ps2data_i each pass through a 2-FF synchronizer, producing sclk and sdat. All decisions use sclk/sdat.
- **Idle counter:** counts while sclk=1 and sdat=1; clears otherwise; saturates at IDLE_CYC. `bus_idle` = counter reaches IDLE_CYC.
- **Half-period timer:** counts 0..HALF_CYC-1. It is reloaded on every state entry. `tick` = terminal count.
- **TX holding register:** loads on tx_valid & tx_ready, which sets `pending` (tx_ready = ~pending). It is cleared only on frame completion.
- **TX frame shift register (11 bits):** {1, odd parity = ~^byte, byte[7:0], 0}. Sent LSB first, so the start bit goes out first.
- **States and transitions:**
  - IDLE → RX_WAIT when sclk=1 & sdat=0 (host request-to-send). This has priority over transmit.
  - IDLE → TX_HIGH when pending & bus_idle. Loads the shift register; bit counter = 0.
  - TX_HIGH: ps2data_oe = ~shift[0]; clock released.
    - On tick: if sclk=0, the host is inhibiting. Pulse tx_abort, release both lines, go to IDLE; pending stays 1.
    - Otherwise go to TX_LOW.
  - TX_LOW: ps2clk_oe=1; data held. On tick:
    - Bit counter = 10: go to IDLE and clear pending.
    - Else: shift, increment the bit counter, go to TX_HIGH.
  - RX_WAIT: both lines released. On tick go to RX_LOW; bit counter = 0.
  - RX_LOW: ps2clk_oe=1. On tick go to RX_HIGH.
  - RX_HIGH: clock released.
    - On tick with sclk=0: host inhibit. Go to IDLE with no rx pulses.
    - Otherwise sample sdat into the RX shift register.
      - Bits 0-7 are data, LSB first. Bit 8 is parity. Bit 9 is stop.
      - After bit 9: stop=1 → ACK_LOW; stop=0 → pulse rx_ferr and go to IDLE.
      - Otherwise increment the bit counter and go to RX_LOW.
  - ACK_LOW: ps2data_oe=1, ps2clk_oe=1. On tick go to ACK_HIGH.
  - ACK_HIGH: ps2data_oe=1, clock released. On tick:
    - release data, go to IDLE;
    - pulse rx_valid with rx_data = received byte and rx_perr = (^{data,parity} == 0).
- Any state value other than those above goes to IDLE.
- **Reset** (any cycle, including mid-frame): FSM to IDLE; pending=0; tx_ready=1; ps2clk_oe=0; ps2data_oe=0; rx_data=0x00; rx_valid=0; rx_perr=0; rx_ferr=0; tx_abort=0; busy=0; all counters 0.

## Timing
- Pin-to-decision latency: 2 clk (synchronizer) plus 1 clk (FSM register).
- TX start: at least IDLE_CYC cycles of sclk=sdat=1 after pending is set.
- TX frame duration: 11 × 2 × HALF_CYC cycles. Data changes only at entry to TX_HIGH, HALF_CYC before the falling clock edge.
- RX: first device clock falls HALF_CYC after the request is detected. Ten sample pulses, then one ACK pulse. Total 11 pulses.
- rx_valid is asserted at the ACK_HIGH tick; the receive-side outputs (rx_valid, rx_perr, rx_ferr) are registered.
- tx_valid while pending=1 is ignored; the source must hold it until tx_ready.
- Request-to-send arriving while pending: the receive is served first, then the transmit retries after bus_idle.

## Test plan
- **Transmit 0x1C** (HALF_CYC=4, IDLE_CYC=10, passive host model) → 11 falling edges. Host-sampled bits 0,0,0,1,1,1,0,0,0,0,1 (parity 0). tx_ready returns to 1 after the 11th low phase.
- **Receive 0xED** (host pulls clk low for 20 cycles, data low, releases clk; host shifts d0..d7, parity=1, stop=1) → 11 device clock pulses; ps2data_oe=1 during pulse 11; rx_valid one cycle; rx_data=0xED; rx_perr=0.
- **Receive 0xED with parity=0** → ACK still given; rx_valid with rx_perr=1. With stop=0 instead → rx_ferr pulse, no ACK, no rx_valid.
- **Inhibit during TX** of 0xAA (host holds clk low during the high phase of bit 4) → tx_abort pulse; lines released; tx_ready stays 0. After the host releases and IDLE_CYC elapses, the full 0xAA frame is resent.
- **Simultaneous request:** pending byte 0x55 and host request-to-send in the same IDLE cycle → receive completes with ACK first, then 0x55 is transmitted.
- **Reset mid-RX** after 5 bits → next cycle ps2clk_oe=0, ps2data_oe=0, busy=0, rx_data=0x00, no rx_valid pulse.
